// File: rtl/wb_arb_rr.sv
// Round-robin Wishbone bus arbiter with a 4-phase REQ/GNT handshake and registered outputs.
// Optional grant-tenure limit is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arb_rr #(
    parameter int NUM_MASTERS    = 4,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   CLK,
    input  logic                   RST_SYNC,
    input  logic                   EN,
    input  logic [NUM_MASTERS-1:0] WB_ARB_REQ_IN,
    output logic [NUM_MASTERS-1:0] WB_ARB_GNT_OUT,
    output logic [IDX_W-1:0]       WB_ARB_IDX_OUT,
    output logic                   WB_ARB_BUSY_OUT,
    output logic                   WB_ARB_TIMEOUT_OUT
);

    if (IDX_W != $clog2(NUM_MASTERS) || NUM_MASTERS < 2 || NUM_MASTERS > 8 ||
        TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("wb_arb_rr: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
`ifdef WB_ARB_TIMEOUT_EN
        , ST_REVOKE = 2'd3
`endif
    } state_t;

    state_t                  r_state;
    logic [NUM_MASTERS-1:0]  r_gnt;
    logic [IDX_W-1:0]        r_last;
    logic                    r_busy;

    state_t                  w_state_nxt;
    logic [NUM_MASTERS-1:0]  w_gnt_nxt;
    logic [IDX_W-1:0]        w_last_nxt;
    logic                    w_busy_nxt;

    logic                    w_req_any;
    logic                    w_owner_req;
    logic [IDX_W-1:0]        w_sel;
    logic [IDX_W-1:0]        w_cand;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic          r_timeout;
    logic [TW-1:0] r_tenure;
    logic          w_timeout_nxt;
    logic [TW-1:0] w_tenure_nxt;
    logic          w_expired;
`endif

    // Candidate k steps after the last owner, wrapped into 0..NUM_MASTERS-1.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
        return IDX_W'(s);
    endfunction

    assign w_req_any   = |WB_ARB_REQ_IN;
    assign w_owner_req = WB_ARB_REQ_IN[r_last];

    // Walk from farthest to nearest so the nearest requester after the last owner wins.
    always_comb begin
        w_sel  = r_last;
        w_cand = r_last;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            w_cand = wrap_add(r_last, k);
            if (WB_ARB_REQ_IN[w_cand]) w_sel = w_cand;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    assign w_expired = (r_tenure == TW'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        // NOTE: every next-value signal is defaulted first so no path leaves one unassigned (no latches).
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        w_busy_nxt  = r_busy;
`ifdef WB_ARB_TIMEOUT_EN
        w_timeout_nxt = 1'b0;
        w_tenure_nxt  = r_tenure;
`endif
        case (r_state)
            ST_IDLE: begin
                if (EN && w_req_any) begin
                    w_gnt_nxt   = NUM_MASTERS'(1) << w_sel;
                    w_last_nxt  = w_sel;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_GRANT;
`ifdef WB_ARB_TIMEOUT_EN
                    w_tenure_nxt = '0;
`endif
                end
            end
            ST_GRANT: begin
                // A normal release outranks tenure expiry in the same cycle.
                if (!w_owner_req) begin
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_RELEASE;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (w_expired) begin
                    w_gnt_nxt     = '0;
                    w_busy_nxt    = 1'b0;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_REVOKE;
                end else begin
                    w_tenure_nxt = r_tenure + TW'(1);
                end
`endif
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
            end
`ifdef WB_ARB_TIMEOUT_EN
            ST_REVOKE: begin
                // The revoked owner must drop REQ before anyone is arbitrated again.
                if (!w_owner_req) w_state_nxt = ST_RELEASE;
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignment so all of them update from pre-edge values.
        if (RST_SYNC) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_last  <= IDX_W'(NUM_MASTERS - 1);
            r_busy  <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
            r_tenure  <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
`ifdef WB_ARB_TIMEOUT_EN
            r_timeout <= w_timeout_nxt;
            r_tenure  <= w_tenure_nxt;
`endif
        end
    end

    assign WB_ARB_GNT_OUT  = r_gnt;
    assign WB_ARB_IDX_OUT  = r_last;
    assign WB_ARB_BUSY_OUT = r_busy;
`ifdef WB_ARB_TIMEOUT_EN
    assign WB_ARB_TIMEOUT_OUT = r_timeout;
`else
    assign WB_ARB_TIMEOUT_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arb_rr.sv
// Self-checking bench for wb_arb_rr: directed scenarios plus randomized masters,
// every cycle compared against a cycle-level behavioural model of the arbitration rules.
module tb_wb_arb_rr;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TO = 16;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  gnt;
    logic [IW-1:0] idx;
    logic          busy;
    logic          tout;

    always #5 clk = ~clk;

    wb_arb_rr #(
        .NUM_MASTERS    (N),
        .IDX_W          (IW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK                (clk),
        .RST_SYNC           (rst),
        .EN                 (en),
        .WB_ARB_REQ_IN      (req),
        .WB_ARB_GNT_OUT     (gnt),
        .WB_ARB_IDX_OUT     (idx),
        .WB_ARB_BUSY_OUT    (busy),
        .WB_ARB_TIMEOUT_OUT (tout)
    );

    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
        else $error("grant vector multi-hot");

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, who was last served, how many dead
    // cycles remain before arbitration, and who was revoked and must let go.
    int m_owner   = -1;
    int m_last    = N - 1;
    int m_dead    = 0;
    int m_revoked = -1;
    int m_tenure  = 0;
    bit m_pulse   = 1'b0;

    task automatic model_step();
        m_pulse = 1'b0;
        if (rst) begin
            m_owner = -1; m_last = N - 1; m_dead = 0; m_revoked = -1; m_tenure = 0;
        end else if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_owner = -1; m_dead = 1;
            end else if (TO_EN && m_tenure == TO - 1) begin
                m_revoked = m_owner; m_owner = -1; m_pulse = 1'b1;
            end else begin
                m_tenure++;
            end
        end else if (m_revoked >= 0) begin
            if (!req[m_revoked]) begin
                m_revoked = -1; m_dead = 1;
            end
        end else if (m_dead > 0) begin
            m_dead--;
        end else if (en && req != '0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (req[c]) begin
                    m_owner = c; m_last = c; m_tenure = 0;
                    break;
                end
            end
        end
    endtask

    task automatic tick();
        logic [N-1:0] exp_gnt;
        @(posedge clk);
        model_step();
        #1;
        exp_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("idx", 32'(idx), 32'(m_last));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("timeout", 32'(tout), 32'(m_pulse));
        check("onehot0", 32'($onehot0(gnt)), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int hold [N];
    int order [$];
    int cnt;
    int gcnt;
    int pulses;
    logic [N-1:0] prev_gnt;

    initial begin
        // Reset state
        do_reset();
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_idx", 32'(idx), 32'd3);

        // Single requester
        en = 1'b1;
        repeat (3) tick();
        req = 4'b0001;
        tick();
        check("single_gnt", 32'(gnt), 32'b0001);
        check("single_idx", 32'(idx), 32'd0);
        repeat (4) tick();
        req = 4'b0000;
        tick();
        check("single_drop", 32'(gnt), 32'd0);
        repeat (3) tick();

        // Simultaneous requests: 0 first, then 2 after a two-cycle gap
        do_reset();
        req = 4'b0101;
        tick();
        check("simul_first", 32'(gnt), 32'b0001);
        repeat (2) tick();
        req = 4'b0100;
        tick();
        check("simul_gap1", 32'(gnt), 32'd0);
        tick();
        check("simul_gap2", 32'(gnt), 32'd0);
        tick();
        check("simul_second", 32'(gnt), 32'b0100);
        req = 4'b0000;
        repeat (3) tick();

        // Fairness: everyone requests, each releases after 3 grant cycles
        do_reset();
        req = '1;
        cnt = 0;
        prev_gnt = '0;
        order.delete();
        for (int c = 0; c < 40; c++) begin
            if (m_owner >= 0) begin
                cnt++;
                if (cnt == 3) req[m_owner] = 1'b0;
            end else begin
                cnt = 0;
                req = '1;
            end
            tick();
            if (gnt != '0 && prev_gnt == '0) order.push_back(int'(idx));
            prev_gnt = gnt;
        end
        check("fair_count", 32'(order.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < order.size(); i++)
            check("fair_order", 32'(order[i]), 32'(i % N));
        req = '0;
        repeat (3) tick();

        // EN gating
        do_reset();
        en = 1'b0;
        req = 4'b0010;
        gcnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (gnt != '0) gcnt++;
        end
        check("en_blocked", 32'(gcnt), 32'd0);
        en = 1'b1;
        tick();
        check("en_grant", 32'(gnt), 32'b0010);
        en = 1'b0;
        repeat (5) tick();
        check("en_hold", 32'(gnt), 32'b0010);
        req = '0;
        tick();
        check("en_release", 32'(gnt), 32'd0);
        en = 1'b1;
        repeat (2) tick();

        // Reset mid-grant: master 2 owns, reset, master 0 next
        req = 4'b0100;
        repeat (2) tick();
        check("mid_gnt", 32'(gnt), 32'b0100);
        req = 4'b0101;
        do_reset();
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        check("mid_rst_idx", 32'(idx), 32'd3);
        tick();
        check("mid_regrant", 32'(gnt), 32'b0001);
        req = '0;
        repeat (3) tick();

`ifdef WB_ARB_TIMEOUT_EN
        // Tenure limit: master 1 overstays, master 3 waits until 1 lets go
        do_reset();
        req = 4'b0010;
        gcnt = 0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 5) req[3] = 1'b1;
            tick();
            if (gnt[1]) gcnt++;
            if (tout) pulses++;
            check("to_no_m3", 32'(gnt[3]), 32'd0);
        end
        check("to_tenure", 32'(gcnt), 32'(TO));
        check("to_pulses", 32'(pulses), 32'd1);
        req[1] = 1'b0;
        tick();
        tick();
        check("to_m3_wait", 32'(gnt), 32'd0);
        tick();
        check("to_m3_grant", 32'(gnt), 32'b1000);
        req = '0;
        repeat (3) tick();
`endif

        // Randomized masters
        do_reset();
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m_owner == i) begin
                    if (hold[i] > 0) hold[i]--;
                    else req[i] = 1'b0;
                end else if (m_revoked == i) begin
                    if ($urandom_range(0, 2) == 0) req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i]  = 1'b1;
                        hold[i] = $urandom_range(0, TO_EN ? 30 : 8);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arb_rr.md
Name: wb_arb_rr

Overview:
Round-robin arbiter that shares the single Wishbone bus between up to NUM_MASTERS bus masters, such as the ADI EPP bridge, a CPU and DMA engines. It implements the 4-phase REQ/GNT handshake the Wishbone master FSMs expect, and replaces the registered GNT<=REQ loopback used in block-level benches. It sits beside the bus and drives only the grant vector and status. Muxing of master bus signals is done elsewhere, using WB_ARB_IDX_OUT.

Parameters:
NUM_MASTERS, 4, number of requesters (2..8)
IDX_W, 2, width of owner index; must equal ceil(log2(NUM_MASTERS))
TIMEOUT_CYCLES, 1024, maximum grant tenure in cycles; used only with WB_ARB_TIMEOUT_EN

Ports:
CLK  in  1  system clock, all logic on rising edge
RST_SYNC  in  1  reset, synchronous, active-high
EN  in  1  arbiter enable; low blocks new grants only
WB_ARB_REQ_IN  in  NUM_MASTERS  per-master request, bit i = master i
WB_ARB_GNT_OUT  out  NUM_MASTERS  one-hot (or zero) registered grant
WB_ARB_IDX_OUT  out  IDX_W  index of current/last owner, drives bus mux select
WB_ARB_BUSY_OUT  out  1  high while any grant is asserted
WB_ARB_TIMEOUT_OUT  out  1  single-cycle pulse on grant revocation

Behaviour:
- Reset (RST_SYNC high at an edge): GNT=0, IDX=NUM_MASTERS-1, BUSY=0, TIMEOUT=0, state IDLE, last-owner pointer=NUM_MASTERS-1, so master 0 has first priority. Reset overrides everything, including mid-grant; GNT drops at that edge.
- All outputs are registered. GNT is always one-hot or zero, never multi-hot.
- FSM states: IDLE, GRANT, RELEASE, REVOKE (REVOKE exists only with the macro).
- IDLE: at an edge with EN=1 and REQ!=0, select the first requesting master searching from last+1 upward with wrap modulo NUM_MASTERS. Set GNT[sel]=1, IDX=sel, BUSY=1, last=sel, and go to GRANT. Latency is REQ sampled at edge n, GNT visible after edge n (one cycle). With EN=0 or REQ=0, stay in IDLE with outputs unchanged (GNT=0).
- GRANT: hold GNT while REQ[owner]=1. Requests from other masters are ignored, with no preemption. When REQ[owner]=0 at an edge: GNT=0, BUSY=0, go to RELEASE. EN has no effect in GRANT.
- RELEASE: one mandatory dead cycle, then go unconditionally to IDLE. Minimum gap between two grants is therefore 2 cycles of GNT=0. This completes the 4-phase handshake: the master sees GNT low before any re-arbitration.
- A master re-raising REQ during RELEASE is legal. It is arbitrated in IDLE, with lowest priority relative to others because of the last pointer.
- IDX holds its value after release; consumers qualify it with BUSY.
- REQ bits of non-existent masters are not possible (the width equals NUM_MASTERS).

Optional Feature:
Macro WB_ARB_TIMEOUT_EN.
- Defined: a tenure counter clears on entry to GRANT and increments each GRANT cycle. When the counter reaches TIMEOUT_CYCLES-1 with REQ[owner] still high: GNT=0, BUSY=0, pulse TIMEOUT for 1 cycle, go to REVOKE. REVOKE waits for REQ[owner]=0, then goes to RELEASE. The owner does not get the bus back without dropping REQ. A normal release in the same cycle as expiry takes precedence, with no pulse.
- Not defined: no counter and no REVOKE state; WB_ARB_TIMEOUT_OUT is tied 0 and tenure is unbounded.

Test Plan:
- Single requester: REQ=0001 at edge 5 -> GNT=0001, IDX=0, BUSY=1 after edge 5. REQ low at edge 10 -> GNT=0000 after edge 10. GNT stays 0 through edge 11.
- Simultaneous requests: after reset, REQ=0101 -> master 0 granted first. Master 0 releases -> master 2 granted exactly 2 cycles after GNT[0] fell.
- Fairness: all four hold REQ=1111 and each releases after 3 cycles, then re-requests immediately -> grant order 0,1,2,3,0,1; never multi-hot (assertion on $onehot0).
- EN gating: EN=0, REQ=0010 -> GNT stays 0000 for 20 cycles. EN=1 -> GNT=0010 next edge. EN dropped during GRANT -> GNT held until REQ falls.
- Reset mid-grant: GNT=0100, RST_SYNC pulsed 1 cycle -> GNT=0000, IDX=3 after that edge. REQ=0101 still high -> master 0 granted next.
- Timeout (macro defined, TIMEOUT_CYCLES=16): master 1 holds REQ for 40 cycles -> GNT[1] falls after 16 grant cycles, with a 1-cycle TIMEOUT pulse. With master 3 requesting, no grant is issued until REQ[1] drops; master 3 is granted 2 cycles later.
